bcd_to_binary_seq: RTL
======================

# bcd_to_binary_seq

Multi-cycle, parametrised packed-BCD to binary converter with valid/ready handshakes on both sides. It processes one decimal digit per clock using Horner's rule (acc = acc*10 + digit, most significant digit first), so a wide N-digit input needs no N-wide multiplier tree. The block also flags non-decimal digits and results that do not fit in OUT_W bits. It sits between BCD sources (keypad/display front-ends, BCD counters) and binary arithmetic datapaths.

## Interface
- N, default 4: number of BCD digits in `bcd_in`; N ≥ 1.
- OUT_W, default 4*N: width of `bin_out`; any value ≥ 4.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `bcd_in` holds a word to convert.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bcd_in  input  4*N  packed BCD; digit i occupies bits [4i+3:4i]; digit N-1 is most significant.
- out_valid  output  1  `bin_out`, `err_digit` and `ovf` hold a finished result.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  OUT_W  binary value of the BCD word, modulo 2^OUT_W.
- err_digit  output  1  at least one input digit was > 9.
- ovf  output  1  the true result is ≥ 2^OUT_W.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch `bcd_in` into the digit shift register, clear acc, count and ovf, and go to CONV.
  - err_digit is computed from the latched word (OR over digits of digit > 9) and set at this same edge.
- CONV: one digit per edge.
  - acc ← (acc*10 + top digit) mod 2^OUT_W, with acc*10 formed as (acc<<3)+(acc<<1).
  - Shift the digit register left by one digit and increment count.
  - Compute the sum at OUT_W+4 bits. If it is ≥ 2^OUT_W, set ovf (sticky for this conversion).
  - On the edge where count = N-1, go to DONE.
- Digits > 9 are used at their raw value (10..15) in the arithmetic. The result is defined but flagged by err_digit.
- DONE:
  - out_valid = 1; `bin_out` = acc, together with err_digit and ovf, stays stable.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE and CONV. Inputs presented there are ignored and not queued.
- Counter width: max(1, ceil(log2 N)). N = 1 must work, giving exactly one CONV cycle.
- rst (any state, including mid-CONV or DONE):
  - Go to IDLE and abort the conversion; the result is discarded.
  - Clear acc, count, digit register, bin_out, err_digit and ovf to 0, and set out_valid to 0.
  - in_ready = 1 from the first cycle after reset.
- Reset values: in_ready=1, out_valid=0, bin_out=0, err_digit=0, ovf=0.

## Timing
- Accept edge = edge T where in_valid & in_ready.
- CONV occupies the cycles after edges T .. T+N-1. out_valid rises after edge T+N (latency N cycles from accept to out_valid).
- bin_out, err_digit and ovf are registered and change only at the accept edge, during CONV, or at rst. They are stable the whole time out_valid = 1.
- Output handshake at edge U (out_valid & out_ready): out_valid = 0 and in_ready = 1 after U. The earliest next accept is edge U+1.
- Max throughput with out_ready held high: one word per N+2 cycles.
- If out_ready is already high when DONE is entered, DONE lasts exactly one cycle.
- rst asserted together with in_valid or out_ready: rst wins. There is no accept and no output handshake.
- in_ready and out_valid are never both 1.

## Test plan
- N=4, OUT_W=16, bcd_in=16'h1234, out_ready=1 → after 4 cycles out_valid=1, bin_out=16'h04D2, err_digit=0, ovf=0. out_valid stays high for exactly 1 cycle, and in_ready=1 on the next cycle.
- N=4, OUT_W=16, inputs 16'h9999 then 16'h0000 back-to-back → bin_out=16'h270F, then 16'h0000. Second accept happens exactly N+2 cycles after the first.
- N=4, bcd_in=16'h12A4 → err_digit=1, bin_out=1*1000+2*100+10*10+4=1304 (16'h0518), ovf=0.
- N=3, OUT_W=8:
  - 12'h255 → bin_out=255, ovf=0.
  - 12'h256 → bin_out=0, ovf=1.
  - 12'h999 → bin_out=999 mod 256=231, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → bin_out, flags and out_valid stay stable, and in_ready=0 throughout. A new in_valid pulse during this time is ignored. Raising out_ready → handshake, then IDLE.
- Reset: assert rst for 1 cycle at the 2nd CONV cycle of 16'h4321, then send 16'h0042 → no out_valid from the aborted word, all outputs are 0 after reset, and the next result is bin_out=42. Also cover N=1, bcd_in=4'h7 → bin_out=7 after 1 cycle.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock via Horner's rule,
// with valid/ready handshakes on input and output and flags for bad digits and overflow.
module bcd_to_binary_seq #(
  parameter int N     = 4,
  parameter int OUT_W = 4 * N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*N-1:0]     bcd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   bin_out,
  output logic               err_digit,
  output logic               ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [4*N-1:0]   digits;
  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    count;
  logic             err_flag;
  logic             ovf_flag;

  logic [3:0]       top_digit;
  logic [OUT_W+3:0] sum;
  logic             last_digit;
  logic             any_bad;

  // Four guard bits hold acc*10 + 15 exactly, so any carry into them means overflow.
  assign top_digit  = digits[4*N-1 -: 4];
  assign sum        = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                    + {{OUT_W{1'b0}}, top_digit};
  assign last_digit = (count == CW'(N - 1));

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid)   state_next = CONV;
      CONV: if (last_digit) state_next = DONE;
      DONE: if (out_ready)  state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      digits   <= '0;
      acc      <= '0;
      count    <= '0;
      err_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            digits   <= bcd_in;
            acc      <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
            err_flag <= any_bad;
          end
        end
        CONV: begin
          acc    <= sum[OUT_W-1:0];
          digits <= digits << 4;
          count  <= count + CW'(1);
          if (|sum[OUT_W+3:OUT_W]) begin
            ovf_flag <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bin_out   = acc;
  assign err_digit = err_flag;
  assign ovf       = ovf_flag;

endmodule
